shift_host_driver: RTL
======================

// Module: shift_host_driver
// PURPOSE
//  Host/tester-side master for the chip's serial load/readout interface (LAD1/LAD2, addr, din, dout_for_chip).
//  Accepts parallel write/read commands and serializes them into LAD-coded address/data shift phases.
//  Captures the 64-bit serial readout and returns it as a parallel response.
//  Sits in the FPGA test harness / bring-up controller that drives the ASIC pins.
// PARAMETERS
//  ADDR_W   10  address width shifted in ADDR phase
//  DATA_W   64  data width shifted in DATA phase / captured in READ phase
//  RD_LEN   67  cycles LAD=11 is held in READ phase
//  RD_SKIP  4   READ-phase cycles before first valid readout bit is captured
// PORTS
//  clk1           in   1   clock, same clock as chip-side interface
//  rst            in   1   reset
//  cmd_valid      in   1   command request
//  cmd_ready      out  1   high in IDLE; command accepted on cmd_valid&cmd_ready edge
//  cmd_write      in   1   1=write, 0=read
//  cmd_addr       in   10  target address
//  cmd_wdata      in   64  write data (ignored for reads)
//  rsp_valid      out  1   one-cycle pulse: command complete
//  rsp_rdata      out  64  captured read data (held until next read completes)
//  rsp_err        out  1   write-verify mismatch, valid with rsp_valid
//  busy           out  1   ~cmd_ready
//  LAD1, LAD2     out  1   phase code {LAD2,LAD1}: 00 NOP, 01 ADDR, 10 DATA, 11 READ
//  addr           out  1   serial address bit, LSB first
//  din            out  1   serial data bit, LSB first
//  dout_for_chip  in   1   serial readout bit from chip (registered chip-side)
// BEHAVIOUR
//  - Reset rst, asynchronous, active-high; clock clk1. All outputs registered.
//  - Reset: state IDLE; LAD1=LAD2=addr=din=0; rsp_valid=rsp_err=0; rsp_rdata=0; cmd_ready=1.
//  - Command latched into internal regs on accept; cmd_* may change afterwards.
//  - States: IDLE -> PRE_NOP(1) -> ADDR(10) -> write: DATA(64) -> POST_NOP(1) -> IDLE.
//  -   read: ADDR(10) -> GAP_NOP(1) -> READ(RD_LEN) -> POST_NOP(1) -> IDLE.
//  - ADDR cycle k (0..9): LAD=01, addr=cmd_addr[k]. DATA cycle k (0..63): LAD=10, din=cmd_wdata[k].
//  - addr/din forced 0 outside their phases; LAD=00 in IDLE and all NOP states.
//  - READ: 7-bit counter rc=0..66 per cycle LAD=11 is driven; bit i=rc-RD_SKIP captured at edge
//    ending cycle rc (rc=4..66 -> bits 0..62); bit 63 captured at edge ending POST_NOP.
//  - NOP before every READ is mandatory (clears chip readout counter); never go ADDR->READ directly.
//  - rsp_valid pulses in first IDLE cycle after POST_NOP; cmd_ready also 1 that cycle (back-to-back ok,
//    next command still starts with PRE_NOP).
//  - Latency accept->rsp_valid: write 77 cycles, read 81 cycles.
//  - cmd_valid while busy: ignored, not queued. rsp_rdata updated only by reads.
//  - Reset mid-operation: immediate abort, LAD=00, no rsp_valid for aborted command.
// CONFIGURATION
//  - SHIFT_HOST_WVERIFY_EN defined: after write POST_NOP, run ADDR(same addr)->GAP_NOP->READ->POST_NOP;
//    compare captured word to written data; rsp_err=1 on mismatch; write latency 157 cycles;
//    rsp_rdata updated with readback.
//  - Undefined: no readback; rsp_err tied 0; write latency 77.
// TESTING
//  - Reset asserted mid-idle -> LAD1=LAD2=addr=din=0, rsp_valid=0, cmd_ready=1.
//  - Write addr=0x2A5, data=0xDEADBEEF_01234567 -> 1 NOP, addr bits 1,0,1,0,0,1,0,1,0,1 with LAD=01,
//    64 din bits LSB-first with LAD=10, NOP, rsp_valid 77 cycles after accept.
//  - Read addr=0x003, chip model returns 0xA5A5_0F0F_1234_8001 -> LAD=11 for 67 cycles,
//    rsp_rdata=0xA5A5_0F0F_1234_8001, rsp_valid 81 cycles after accept.
//  - cmd_valid held high with write then read -> second accepted on rsp_valid cycle, NOP precedes ADDR.
//  - rst pulsed at DATA cycle 30 -> LAD=00 next edge, no rsp_valid; following read returns correct data.
//  - SHIFT_HOST_WVERIFY_EN, model flips bit 17 on readback -> rsp_err=1; clean model -> rsp_err=0.

Source files
------------

// File: rtl/shift_host_if.sv
// rtl/shift_host_if.sv - command/response and chip-pin bundle for the serial load/readout host master
interface shift_host_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              LAD1;
    logic              LAD2;
    logic              addr;
    logic              din;
    logic              dout_for_chip;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, dout_for_chip,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, LAD1, LAD2, addr, din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, dout_for_chip,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, LAD1, LAD2, addr, din
    );
endinterface

// File: rtl/shift_host_driver.sv
// rtl/shift_host_driver.sv - LAD-coded serial load/readout master; SHIFT_HOST_WVERIFY_EN adds write readback verify
module shift_host_driver #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int RD_LEN  = 67,
    parameter int RD_SKIP = 4
) (
    input  logic         clk1,
    input  logic         rst,
    shift_host_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_NOP,
        S_ADDR,
        S_DATA,
        S_GAP_NOP,
        S_READ,
        S_POST_NOP
    } state_t;

    localparam logic [6:0] ADDR_LAST = 7'(ADDR_W - 1);
    localparam logic [6:0] DATA_LAST = 7'(DATA_W - 1);
    localparam logic [6:0] RD_LAST   = 7'(RD_LEN - 1);
    localparam logic [6:0] RD_FIRST  = 7'(RD_SKIP);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [6:0]        r_cnt;
    logic [6:0]        w_cnt_nxt;
    logic              w_accept;
    logic              w_verify_start;
    logic              w_done;
    logic              w_read_done;
    logic              r_write;
    logic              r_verify;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [DATA_W-1:0] r_data_sh;
    logic [DATA_W-2:0] r_rx;
    logic [DATA_W-1:0] w_rx_word;
    logic [DATA_W-1:0] r_rdata;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_lad1;
    logic              r_lad2;
    logic              r_addr_o;
    logic              r_din_o;

    assign w_accept    = bus.cmd_valid & r_cmd_ready;
    assign w_done      = (r_state == S_POST_NOP) && (w_state_nxt == S_IDLE);
    assign w_read_done = (r_state == S_POST_NOP) && (!r_write || r_verify);
    // Readout bit 63 arrives during POST_NOP, so the word is completed combinationally
    assign w_rx_word   = {bus.dout_for_chip, r_rx};

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + 7'd1;
        w_verify_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) w_state_nxt = S_PRE_NOP;
            end
            S_PRE_NOP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (r_cnt == ADDR_LAST) begin
                    w_cnt_nxt   = '0;
                    // The NOP before READ clears the chip readout counter; never skip it
                    w_state_nxt = (r_write && !r_verify) ? S_DATA : S_GAP_NOP;
                end
            end
            S_DATA: begin
                if (r_cnt == DATA_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_POST_NOP;
                end
            end
            S_GAP_NOP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_READ;
            end
            S_READ: begin
                if (r_cnt == RD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_POST_NOP;
                end
            end
            S_POST_NOP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
`ifdef SHIFT_HOST_WVERIFY_EN
                if (r_write && !r_verify) begin
                    w_state_nxt    = S_PRE_NOP;
                    w_verify_start = 1'b1;
                end
`endif
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_verify <= 1'b0;
            r_addr   <= '0;
        end else if (w_accept) begin
            r_write  <= bus.cmd_write;
            r_addr   <= bus.cmd_addr;
            r_verify <= 1'b0;
        end else if (w_verify_start) begin
            r_verify <= 1'b1;
        end
    end

    // Pin outputs are registered from the next state so they line up with the phase
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_addr_sh   <= '0;
            r_data_sh   <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_addr_o    <= 1'b0;
            r_din_o     <= 1'b0;
            r_lad1      <= 1'b0;
            r_lad2      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_state_nxt == S_PRE_NOP) begin
                r_addr_sh <= w_accept ? bus.cmd_addr : r_addr;
                if (w_accept) r_data_sh <= bus.cmd_wdata;
            end else if (w_state_nxt == S_ADDR) begin
                r_addr_sh <= r_addr_sh >> 1;
            end else if (w_state_nxt == S_DATA) begin
                r_data_sh <= r_data_sh >> 1;
            end
            r_addr_o    <= (w_state_nxt == S_ADDR) & r_addr_sh[0];
            r_din_o     <= (w_state_nxt == S_DATA) & r_data_sh[0];
            r_lad1      <= (w_state_nxt == S_ADDR) | (w_state_nxt == S_READ);
            r_lad2      <= (w_state_nxt == S_DATA) | (w_state_nxt == S_READ);
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rsp_valid <= w_done;
            if ((r_state == S_READ) && (r_cnt >= RD_FIRST))
                r_rx <= {bus.dout_for_chip, r_rx[DATA_W-2:1]};
            if (w_read_done) r_rdata <= w_rx_word;
        end
    end

`ifdef SHIFT_HOST_WVERIFY_EN
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) r_wdata <= bus.cmd_wdata;
            r_err <= w_done & r_write & (w_rx_word != r_wdata);
        end
    end

    assign bus.rsp_err = r_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.LAD1      = r_lad1;
    assign bus.LAD2      = r_lad2;
    assign bus.addr      = r_addr_o;
    assign bus.din       = r_din_o;
endmodule
